// File: rtl/host_pkg.sv
// host_pkg
//   Shared definitions for the host receive path: the assembler state
//   encoding, default sizing and the host command codes.
package host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COLLECT   = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam int MAX_BYTES_DEFAULT      = 128;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1000;

    // Host command codes carried in payload byte 0.
    localparam logic [7:0] CMD_ENCRYPT_CONFIG = 8'h01;
    localparam logic [7:0] CMD_READ_YAW       = 8'h03;

endpackage

// File: rtl/host_rx_timeout_counter.sv
// host_rx_timeout_counter
//   Counts idle cycles while enabled and emits a registered one-cycle
//   pulse on the cycle the count reaches TIMEOUT_CYCLES.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       restart the count from zero (wins over enable)
//   enable      count this cycle
//   expired     one-cycle pulse: TIMEOUT_CYCLES enabled cycles since clear
module host_rx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (enable) begin
            count   <= count + 1'b1;
            // Registered so the pulse lines up with count == TIMEOUT_CYCLES.
            expired <= (count == LAST);
        end else begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/host_rx_packet_assembler.sv
// host_rx_packet_assembler
//   Collects a length-prefixed byte frame from the host link into one wide
//   packet word, strobes it to the downstream decoder and holds it (with
//   backpressure on the byte source) until the decoder reports done.
//   Bad lengths and stalled frames are dropped with a frame_error pulse.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rx_byte/valid/ready   byte stream from the host link
//   input_data            assembled packet, payload byte k at [8k+7:8k]
//   send_packet           one-cycle strobe, input_data valid
//   done, error           downstream completion and its error flag
//   frame_error           one-cycle pulse, frame discarded
//   last_error            error captured at the most recent done
//   busy                  assembler not idle
module host_rx_packet_assembler
    import host_pkg::*;
#(
    parameter int MAX_BYTES      = MAX_BYTES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [MAX_BYTES*8-1:0] input_data,
    output logic                   send_packet,
    input  logic                   done,
    input  logic                   error,
    output logic                   frame_error,
    output logic                   last_error,
    output logic                   busy
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [8:0] MAX_LEN = 9'(MAX_BYTES);

    state_t           state, state_next;
    logic [IDX_W-1:0] index;
    logic [7:0]       remaining;
    logic             len_error;
    logic             expired;
    logic             len_ok;
    logic             load_frame, store_byte, last_byte;
    logic             bad_len, drop_frame, take_done;
    logic             timer_clear, timer_enable;

    assign len_ok = (rx_byte != 8'd0) && ({1'b0, rx_byte} <= MAX_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        load_frame = 1'b0;
        store_byte = 1'b0;
        last_byte  = 1'b0;
        bad_len    = 1'b0;
        drop_frame = 1'b0;
        take_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (len_ok) begin
                        load_frame = 1'b1;
                        state_next = ST_COLLECT;
                    end else begin
                        bad_len = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                // The expiring cycle refuses bytes so none lands in a
                // frame that is being thrown away.
                if (expired) begin
                    drop_frame = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    rx_ready = 1'b1;
                    if (rx_valid) begin
                        store_byte = 1'b1;
                        if (remaining == 8'd1) begin
                            last_byte  = 1'b1;
                            state_next = ST_SEND;
                        end
                    end
                end
            end
            ST_SEND: state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (done) begin
                    take_done  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // NOTE: the packet register is reset like any other flop; it is the
    // decoder-facing output and must read as zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            input_data  <= '0;
            index       <= '0;
            remaining   <= '0;
            send_packet <= 1'b0;
            len_error   <= 1'b0;
            last_error  <= 1'b0;
        end else begin
            send_packet <= last_byte;
            len_error   <= bad_len;
            if (take_done) last_error <= error;
            if (load_frame) begin
                // Clearing on load keeps unwritten payload bytes at zero.
                input_data <= '0;
                remaining  <= rx_byte;
                index      <= '0;
            end else if (store_byte) begin
                input_data[{index, 3'b000} +: 8] <= rx_byte;
                remaining <= remaining - 1'b1;
                index     <= index + 1'b1;
            end else if (drop_frame) begin
                input_data <= '0;
            end
        end
    end

    assign timer_clear  = (state != ST_COLLECT) || store_byte;
    assign timer_enable = (state == ST_COLLECT) && !expired;

    host_rx_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(expired)
    );

    // Both sources are flops and expired can only be high in COLLECT, so
    // the merged pulse is glitch-free and lands on the expiring cycle.
    assign frame_error = len_error | expired;

endmodule
